// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the forwarding/hazard controller: operand-select codes and stall FSM states.
// Optional WB-stage bypass is enabled by defining FWD_WB_BYPASS_EN.
package hazard_forward_ctrl_pkg;

  localparam int DEF_REG_AW   = 5;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_STALL_CW = 16;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10,
    FWD_WB     = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } stall_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for hazard_forward_ctrl: register ids and write enables in, selects/enables out.
// WB_regWrite/WB_rd exist only when FWD_WB_BYPASS_EN is defined.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
);
  logic [REG_AW-1:0]   IF_ID_rs;
  logic [REG_AW-1:0]   IF_ID_rt;
  logic [REG_AW-1:0]   ID_EX_rs;
  logic [REG_AW-1:0]   ID_EX_rt;
  logic                ID_EX_memRead;
  logic                EX_MEM_regWrite;
  logic [REG_AW-1:0]   EX_MEM_rd;
  logic                EX_MEM_memRead;
  logic                MEM_WB_regWrite;
  logic [REG_AW-1:0]   MEM_WB_rd;
`ifdef FWD_WB_BYPASS_EN
  logic                WB_regWrite;
  logic [REG_AW-1:0]   WB_rd;
`endif
  logic [1:0]          ForwardA;
  logic [1:0]          ForwardB;
  logic                pc_write;
  logic                IF_ID_write;
  logic                ID_EX_bubble;
  logic                mem_stall;
  logic [STALL_CW-1:0] stall_count;

  modport master (
    output IF_ID_rs, IF_ID_rt, ID_EX_rs, ID_EX_rt, ID_EX_memRead,
           EX_MEM_regWrite, EX_MEM_rd, EX_MEM_memRead, MEM_WB_regWrite, MEM_WB_rd,
`ifdef FWD_WB_BYPASS_EN
           WB_regWrite, WB_rd,
`endif
    input  ForwardA, ForwardB, pc_write, IF_ID_write, ID_EX_bubble, mem_stall, stall_count
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, ID_EX_rs, ID_EX_rt, ID_EX_memRead,
           EX_MEM_regWrite, EX_MEM_rd, EX_MEM_memRead, MEM_WB_regWrite, MEM_WB_rd,
`ifdef FWD_WB_BYPASS_EN
           WB_regWrite, WB_rd,
`endif
    output ForwardA, ForwardB, pc_write, IF_ID_write, ID_EX_bubble, mem_stall, stall_count
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Single-operand forwarding comparator: EX/MEM > MEM/WB > WB > register file; r0 never forwards.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_reg,
  input  logic              ex_mem_we,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_we,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  output fwd_sel_e          sel
);

  logic hit_ex_mem, hit_mem_wb, hit_wb;

  assign hit_ex_mem = ex_mem_we && (ex_mem_rd != '0) && (ex_mem_rd == src_reg);
  assign hit_mem_wb = mem_wb_we && (mem_wb_rd != '0) && (mem_wb_rd == src_reg);
  assign hit_wb     = wb_we     && (wb_rd     != '0) && (wb_rd     == src_reg);

  always_comb begin
    sel = FWD_REG;
    if (hit_ex_mem)      sel = FWD_EX_MEM;
    else if (hit_mem_wb) sel = FWD_MEM_WB;
    else if (hit_wb)     sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding selects, load-use bubble, multi-cycle memory stall FSM and saturating stall counter.
// Defining FWD_WB_BYPASS_EN adds the WB-stage bypass source (select 11).
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int STALL_CW = DEF_STALL_CW
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_ctrl_if.slave bus
);

  localparam int                CNT_W       = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic              MULTI_CYCLE = (MEM_LAT > 1);

  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  fwd_sel_e          fwd_a, fwd_b;

`ifdef FWD_WB_BYPASS_EN
  assign wb_we = bus.WB_regWrite;
  assign wb_rd = bus.WB_rd;
`else
  assign wb_we = 1'b0;
  assign wb_rd = '0;
`endif

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_reg   (bus.ID_EX_rs),
    .ex_mem_we (bus.EX_MEM_regWrite),
    .ex_mem_rd (bus.EX_MEM_rd),
    .mem_wb_we (bus.MEM_WB_regWrite),
    .mem_wb_rd (bus.MEM_WB_rd),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .sel       (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_reg   (bus.ID_EX_rt),
    .ex_mem_we (bus.EX_MEM_regWrite),
    .ex_mem_rd (bus.EX_MEM_rd),
    .mem_wb_we (bus.MEM_WB_regWrite),
    .mem_wb_rd (bus.MEM_WB_rd),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .sel       (fwd_b)
  );

  assign bus.ForwardA = fwd_a;
  assign bus.ForwardB = fwd_b;

  stall_state_e        state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                mem_stall;
  logic                lu, lu_bubble;
  logic [STALL_CW-1:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Gating with reset keeps the enables in their run values while reset is held.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_RUN: begin
          mem_stall = bus.EX_MEM_memRead & MULTI_CYCLE;
          if (mem_stall) begin
            state_nxt = ST_MEM_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
        ST_MEM_WAIT: begin
          mem_stall = (cnt != '0);
          if (cnt != '0) cnt_nxt = cnt - 1'b1;
          else           state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  assign lu = bus.ID_EX_memRead && (bus.ID_EX_rt != '0) &&
              ((bus.ID_EX_rt == bus.IF_ID_rs) || (bus.ID_EX_rt == bus.IF_ID_rt));

  // A freeze dominates the bubble; a pending load-use is re-evaluated once the freeze lifts.
  assign lu_bubble = lu && !mem_stall && !reset;

  assign bus.pc_write     = !(mem_stall || lu_bubble);
  assign bus.IF_ID_write  = !(mem_stall || lu_bubble);
  assign bus.ID_EX_bubble = lu_bubble;
  assign bus.mem_stall    = mem_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if ((mem_stall || lu_bubble) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.stall_count = stall_cnt;

endmodule
